layer3_weight_dispatcher: RTL and testbench
===========================================

// Module: layer3_weight_dispatcher
// PURPOSE
// - Upstream feeder for the layer3 downsampling basic block. Takes one serial
//   weight stream (weight_in/valid_in), counts words, and steers them in order
//   onto the block's three weight ports.
// - Order of the three ports: conv1 (stride-2), conv2 (3x3), conv3 (1x1 shortcut).
// - Holds off upstream with ready_out outside a load, and reports busy/done to
//   the network controller.
// PARAMETERS
// - DATA_WIDTH  32            word width (fp32 weights)
// - NUM_W1      128*256*1     words for conv1
// - NUM_W2      256*256*9     words for conv2
// - NUM_W3      128*256*1     words for conv3 (shortcut)
// - CNT_WIDTH   $clog2 of max(NUM_W1,NUM_W2,NUM_W3)   word counter width
// PORTS
// - clk               in   1           rising-edge clock
// - reset             in   1           async, active-high
// - start             in   1           1-cycle pulse: begin a full load
// - valid_in          in   1           upstream word valid
// - weight_in         in   DATA_WIDTH  upstream weight word
// - ready_out         out  1           dispatcher accepts a word this cycle
// - valid_weight_out1 out  1           conv1 weight strobe
// - weight_out1       out  DATA_WIDTH  conv1 weight
// - valid_weight_out2 out  1           conv2 weight strobe
// - weight_out2       out  DATA_WIDTH  conv2 weight
// - valid_weight_out3 out  1           conv3 weight strobe
// - weight_out3       out  DATA_WIDTH  conv3 weight
// - busy              out  1           high while in LOAD1..LOAD3
// - done              out  1           1-cycle pulse after last conv3 word
// BEHAVIOUR
// - Clock and reset: single clock; reset is asynchronous, active-high.
// - Reset: state=IDLE, counter=0, every output 0 (including all weight_outN).
// - FSM IDLE -> LOAD1 -> LOAD2 -> LOAD3 -> IDLE:
//   - IDLE: leave on start.
//   - LOADn: advance when the word with cnt==NUM_Wn-1 is accepted; counter clears to 0.
// - ready_out is combinational: 1 exactly in LOAD1..LOAD3. busy equals ready_out.
// - Accept: valid_in & ready_out. Registered 1-cycle latency: next cycle
//   valid_weight_outN=1 and weight_outN=word for the active LOADn; the other
//   two valids are 0.
// - Weight data: weight_outN holds its last value when its valid is 0;
//   data passes bit-exact.
// - No accept -> no strobe. Gaps on valid_in are allowed; the counter holds.
// - done: pulses 1 cycle, the same cycle as the final valid_weight_out3.
// - start while busy is ignored and does not restart the count.
// - start and valid_in in the same IDLE cycle: the FSM enters LOAD1; that word is
//   not consumed (ready_out=0 in IDLE), so upstream must hold it.
// - valid_in in IDLE is ignored. No strobe is produced.
// - Reset mid-load aborts immediately. A partially loaded conv has no valid
//   contract; the next start reloads all three from word 0.
// - Counter never exceeds NUM_Wn-1. NUM_Wn=1 is legal: one word, then next state.
// STRUCTURE
// - Shared package: state encoding (IDLE/LOAD1/LOAD2/LOAD3) and the default
//   NUM_W* constants for layer3, reused by the layer4 dispatcher.
// - Single flat module. One natural sub-module: weight_word_counter
//   (load-count with terminal-count flag, parameter CNT_WIDTH).
// TESTING (bench with NUM_W1=4, NUM_W2=9, NUM_W3=2)
// - Reset then idle, valid_in=1 with data -> all valids 0, ready_out=0, busy=0.
// - start, then 15 back-to-back words 1..15 ->
//   - port1 gets 1..4, port2 gets 5..13, port3 gets 14..15, each 1 cycle after accept;
//   - done pulses with word 15; busy drops the following cycle.
// - Same load, valid_in toggled 1/0 every cycle -> identical port contents and
//   order; no spurious strobes in gap cycles.
// - start pulsed during LOAD2 at word 7 -> ignored; load completes normally,
//   done exactly once.
// - Reset asserted after word 6 -> outputs 0 at once. Then start plus 15 words ->
//   the full correct distribution from word 1 again.
// - start and valid_in=1 (data 0xAAAA_AAAA) in the same IDLE cycle, held one more
//   cycle -> word accepted once, appears on port1 as word 0 of conv1.

Source files
------------

// File: rtl/layer3_weight_dispatcher_pkg.sv
// Shared definitions for the layer weight dispatchers: state encoding,
// default layer3 word counts and the counter width helper.
package layer3_weight_dispatcher_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned L3_NUM_W1 = 128 * 256 * 1;
  localparam int unsigned L3_NUM_W2 = 256 * 256 * 9;
  localparam int unsigned L3_NUM_W3 = 128 * 256 * 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD1 = 2'd1,
    LOAD2 = 2'd2,
    LOAD3 = 2'd3
  } dispatch_state_e;

  // Width able to index the largest conv; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n1,
                                            input int unsigned n2,
                                            input int unsigned n3);
    int unsigned m;
    m = n1;
    if (n2 > m) m = n2;
    if (n3 > m) m = n3;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/layer3_weight_dispatcher_if.sv
// Upstream stream, per-conv weight ports and status of the weight dispatcher.
interface layer3_weight_dispatcher_if
  import layer3_weight_dispatcher_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
);
  logic                  start;
  logic                  valid_in;
  logic [DATA_WIDTH-1:0] weight_in;
  logic                  ready_out;
  logic                  valid_weight_out1;
  logic [DATA_WIDTH-1:0] weight_out1;
  logic                  valid_weight_out2;
  logic [DATA_WIDTH-1:0] weight_out2;
  logic                  valid_weight_out3;
  logic [DATA_WIDTH-1:0] weight_out3;
  logic                  busy;
  logic                  done;

  modport master (
    output start, valid_in, weight_in,
    input  ready_out, valid_weight_out1, weight_out1, valid_weight_out2, weight_out2,
    input  valid_weight_out3, weight_out3, busy, done
  );

  modport slave (
    input  start, valid_in, weight_in,
    output ready_out, valid_weight_out1, weight_out1, valid_weight_out2, weight_out2,
    output valid_weight_out3, weight_out3, busy, done
  );
endinterface

// File: rtl/layer3_weight_dispatcher_weight_word_counter.sv
// Word counter for one conv load: counts accepted words and wraps to 0 on the
// terminal index so the next conv starts from word 0.
module layer3_weight_dispatcher_weight_word_counter #(
  parameter int unsigned CNT_WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 en,
  input  logic [CNT_WIDTH-1:0] last_idx,
  output logic                 tc_c
);
  logic [CNT_WIDTH-1:0] count;

  assign tc_c = (count == last_idx);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || (en && tc_c)) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_WIDTH'(1);
    end
  end
endmodule

// File: rtl/layer3_weight_dispatcher.sv
// Steers a serial weight stream in order onto the conv1, conv2 and conv3
// weight ports of the layer3 downsampling block.
module layer3_weight_dispatcher
  import layer3_weight_dispatcher_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned NUM_W1     = L3_NUM_W1,
  parameter int unsigned NUM_W2     = L3_NUM_W2,
  parameter int unsigned NUM_W3     = L3_NUM_W3,
  parameter int unsigned CNT_WIDTH  = cnt_width(NUM_W1, NUM_W2, NUM_W3)
) (
  input logic                       clk,
  input logic                       reset,
  layer3_weight_dispatcher_if.slave bus
);
  dispatch_state_e       state;
  logic                  accept_c;
  logic                  tc_c;
  logic [CNT_WIDTH-1:0]  last_idx_c;
  logic                  valid1, valid2, valid3, done_q;
  logic [DATA_WIDTH-1:0] word1, word2, word3;

  assign accept_c = bus.valid_in && (state != IDLE);

  // Terminal word index of the conv currently being loaded.
  always_comb begin
    last_idx_c = '0;
    case (state)
      LOAD1:   last_idx_c = CNT_WIDTH'(NUM_W1 - 1);
      LOAD2:   last_idx_c = CNT_WIDTH'(NUM_W2 - 1);
      LOAD3:   last_idx_c = CNT_WIDTH'(NUM_W3 - 1);
      default: last_idx_c = '0;
    endcase
  end

  layer3_weight_dispatcher_weight_word_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_counter (
    .clk      (clk),
    .reset    (reset),
    .clear    (state == IDLE),
    .en       (accept_c),
    .last_idx (last_idx_c),
    .tc_c     (tc_c)
  );

  // Load sequencing with registered strobes; data registers hold between strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      valid1 <= 1'b0;
      valid2 <= 1'b0;
      valid3 <= 1'b0;
      done_q <= 1'b0;
      word1  <= '0;
      word2  <= '0;
      word3  <= '0;
    end else begin
      valid1 <= 1'b0;
      valid2 <= 1'b0;
      valid3 <= 1'b0;
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) state <= LOAD1;
        end
        LOAD1: begin
          if (accept_c) begin
            valid1 <= 1'b1;
            word1  <= bus.weight_in;
            if (tc_c) state <= LOAD2;
          end
        end
        LOAD2: begin
          if (accept_c) begin
            valid2 <= 1'b1;
            word2  <= bus.weight_in;
            if (tc_c) state <= LOAD3;
          end
        end
        LOAD3: begin
          if (accept_c) begin
            valid3 <= 1'b1;
            word3  <= bus.weight_in;
            if (tc_c) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready_out         = (state != IDLE);
  assign bus.busy              = (state != IDLE);
  assign bus.done              = done_q;
  assign bus.valid_weight_out1 = valid1;
  assign bus.valid_weight_out2 = valid2;
  assign bus.valid_weight_out3 = valid3;
  assign bus.weight_out1       = word1;
  assign bus.weight_out2       = word2;
  assign bus.weight_out3       = word3;
endmodule

// File: tb/tb_layer3_weight_dispatcher.sv
// Self-checking bench for layer3_weight_dispatcher with small conv sizes,
// compared cycle by cycle against a flat word-index reference model.
module tb_layer3_weight_dispatcher;
  localparam int unsigned DW    = 32;
  localparam int unsigned N1    = 4;
  localparam int unsigned N2    = 9;
  localparam int unsigned N3    = 2;
  localparam int unsigned TOTAL = N1 + N2 + N3;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  layer3_weight_dispatcher_if #(.DATA_WIDTH(DW)) bus ();

  layer3_weight_dispatcher #(
    .DATA_WIDTH (DW),
    .NUM_W1     (N1),
    .NUM_W2     (N2),
    .NUM_W3     (N3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: load is a flat sequence of TOTAL words split by index.
  bit          m_active;
  int          m_idx;
  bit          m_v [3];
  logic [31:0] m_w [3];
  bit          m_done;
  logic [31:0] acc_q[$];
  logic [31:0] got1[$], got2[$], got3[$];
  int          done_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_idx    = 0;
    m_done   = 1'b0;
    for (int p = 0; p < 3; p++) begin
      m_v[p] = 1'b0;
      m_w[p] = '0;
    end
  endtask

  task automatic model_step();
    int p;
    if (reset) begin
      model_reset();
      return;
    end
    for (int q = 0; q < 3; q++) m_v[q] = 1'b0;
    m_done = 1'b0;
    if (m_active && bus.valid_in) begin
      p = (m_idx < int'(N1)) ? 0 : (m_idx < int'(N1 + N2)) ? 1 : 2;
      m_v[p] = 1'b1;
      m_w[p] = bus.weight_in;
      acc_q.push_back(bus.weight_in);
      m_idx++;
      if (m_idx == int'(TOTAL)) begin
        m_active = 1'b0;
        m_idx    = 0;
        m_done   = 1'b1;
      end
    end else if (!m_active && bus.start) begin
      m_active = 1'b1;
    end
  endtask

  task automatic check_outputs();
    check("ready", 64'(bus.ready_out), 64'(m_active));
    check("busy", 64'(bus.busy), 64'(m_active));
    check("done", 64'(bus.done), 64'(m_done));
    check("v1", 64'(bus.valid_weight_out1), 64'(m_v[0]));
    check("v2", 64'(bus.valid_weight_out2), 64'(m_v[1]));
    check("v3", 64'(bus.valid_weight_out3), 64'(m_v[2]));
    check("w1", 64'(bus.weight_out1), 64'(m_w[0]));
    check("w2", 64'(bus.weight_out2), 64'(m_w[1]));
    check("w3", 64'(bus.weight_out3), 64'(m_w[2]));
    if (bus.valid_weight_out1) got1.push_back(bus.weight_out1);
    if (bus.valid_weight_out2) got2.push_back(bus.weight_out2);
    if (bus.valid_weight_out3) got3.push_back(bus.weight_out3);
    if (bus.done) done_cnt++;
  endtask

  // Drive at the falling edge, model at the rising edge, check at the next falling edge.
  task automatic tick(input bit s, input bit v, input logic [31:0] d);
    bus.start    = s;
    bus.valid_in = v;
    bus.weight_in = d;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic clear_logs();
    acc_q.delete();
    got1.delete();
    got2.delete();
    got3.delete();
    done_cnt = 0;
  endtask

  task automatic verify_load(input string tag);
    check({tag, "_n1"}, 64'(got1.size()), 64'(N1));
    check({tag, "_n2"}, 64'(got2.size()), 64'(N2));
    check({tag, "_n3"}, 64'(got3.size()), 64'(N3));
    check({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    if (acc_q.size() == TOTAL && got1.size() == N1 && got2.size() == N2 && got3.size() == N3) begin
      for (int k = 0; k < int'(N1); k++) check({tag, "_p1"}, 64'(got1[k]), 64'(acc_q[k]));
      for (int k = 0; k < int'(N2); k++) check({tag, "_p2"}, 64'(got2[k]), 64'(acc_q[N1 + k]));
      for (int k = 0; k < int'(N3); k++) check({tag, "_p3"}, 64'(got3[k]), 64'(acc_q[N1 + N2 + k]));
    end else begin
      check({tag, "_accepted"}, 64'(acc_q.size()), 64'(TOTAL));
    end
  endtask

  // Words 1..TOTAL land as 1..N1 on port1, then port2, then port3.
  task automatic check_counting(input string tag);
    for (int k = 0; k < int'(N1); k++)
      check({tag, "_c1"}, (k < got1.size()) ? 64'(got1[k]) : 64'hdead, 64'(k + 1));
    for (int k = 0; k < int'(N2); k++)
      check({tag, "_c2"}, (k < got2.size()) ? 64'(got2[k]) : 64'hdead, 64'(N1 + k + 1));
    for (int k = 0; k < int'(N3); k++)
      check({tag, "_c3"}, (k < got3.size()) ? 64'(got3[k]) : 64'hdead, 64'(N1 + N2 + k + 1));
  endtask

  initial begin
    int cyc;
    bus.start = 1'b0;
    bus.valid_in = 1'b0;
    bus.weight_in = '0;
    model_reset();
    clear_logs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs();
    reset = 1'b0;

    // Idle with valid data: nothing accepted, no strobes.
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, $urandom);
    check("idle_accepts", 64'(acc_q.size()), 64'd0);
    clear_logs();

    // Back-to-back load of 1..15.
    tick(1'b1, 1'b0, '0);
    for (int i = 1; i <= int'(TOTAL); i++) tick(1'b0, 1'b1, 32'(i));
    tick(1'b0, 1'b0, '0);
    verify_load("b2b");
    check_counting("b2b");
    clear_logs();

    // valid_in toggling every cycle.
    tick(1'b1, 1'b0, '0);
    for (int i = 1; i <= int'(TOTAL); i++) begin
      tick(1'b0, 1'b1, 32'(i));
      tick(1'b0, 1'b0, $urandom);
    end
    verify_load("gap");
    check_counting("gap");
    clear_logs();

    // start pulsed alongside word 7 (in LOAD2) is ignored.
    tick(1'b1, 1'b0, '0);
    for (int i = 1; i <= int'(TOTAL); i++) tick(i == 7, 1'b1, 32'(i));
    tick(1'b0, 1'b0, '0);
    tick(1'b0, 1'b0, '0);
    verify_load("start_busy");
    check_counting("start_busy");
    clear_logs();

    // Reset after word 6 clears outputs immediately; full reload follows.
    tick(1'b1, 1'b0, '0);
    for (int i = 1; i <= 6; i++) tick(1'b0, 1'b1, 32'(i));
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs();
    tick(1'b0, 1'b1, 32'h5555_5555);
    reset = 1'b0;
    clear_logs();
    tick(1'b1, 1'b0, '0);
    for (int i = 1; i <= int'(TOTAL); i++) tick(1'b0, 1'b1, 32'(i));
    verify_load("after_rst");
    check_counting("after_rst");
    clear_logs();

    // start and valid in the same IDLE cycle; word held and taken once.
    tick(1'b1, 1'b1, 32'hAAAA_AAAA);
    tick(1'b0, 1'b1, 32'hAAAA_AAAA);
    for (int i = 2; i <= int'(TOTAL); i++) tick(1'b0, 1'b1, 32'(i));
    verify_load("same_cyc");
    check("same_cyc_first", (got1.size() > 0) ? 64'(got1[0]) : 64'hdead, 64'hAAAA_AAAA);
    clear_logs();

    // Randomised loads: random gaps, data and spurious starts.
    for (int r = 0; r < 6; r++) begin
      tick(1'b1, 1'($urandom_range(0, 1)), $urandom);
      cyc = 0;
      while (m_active && cyc < 300) begin
        tick(($urandom_range(0, 7) == 0), ($urandom_range(0, 2) != 0), $urandom);
        cyc++;
      end
      check("rand_timeout", 64'(m_active), 64'd0);
      tick(1'b0, 1'b0, $urandom);
      verify_load("rand");
      clear_logs();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
